// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions.
// Frame constants, FSM state type and a parity helper.
package ps2_pkg;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START      = 1'b0;
  localparam logic PS2_STOP       = 1'b1;

  typedef enum logic {
    PS2_IDLE = 1'b0,
    PS2_RECV = 1'b1
  } ps2_state_e;

  // Odd parity over data+parity holds when the XOR is 1.
  function automatic logic ps2_odd_ok(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code FIFO, 2**AW entries, wrap-bit pointers.
// Ports: clk, clrn, push, pop, din[7:0], dout[7:0], empty, full.
module ps2_fifo #(
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_pop;
  logic        do_push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop on a full FIFO frees the slot the push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr <= wptr + (AW+1)'(1);
      end
      if (do_pop)
        rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: sync, deframe, check, queue.
// Ports: clk, clrn, ps2_clk, ps2_data, nextdata_n -> data, ready, overflow, frame_err.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s1, clk_s2, clk_h;
  logic dat_s1, dat_s2;
  logic fall;

  ps2_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [10:1]   shreg_q, shreg_d;
  logic          done_q, done_d;
  logic          tout;

  logic       frame_ok;
  logic       push;
  logic       pop;
  logic       ovf_set;
  logic       bad;
  logic       empty;
  logic       full;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_h  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_h  <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_h && !clk_s2;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= PS2_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    tout    = 1'b0;
    unique case (state_q)
      PS2_IDLE: begin
        tcnt_d = '0;
        if (fall && dat_s2 == PS2_START) begin
          state_d = PS2_RECV;
          cnt_d   = 4'd1;
        end
      end
      PS2_RECV: begin
        if (fall) begin
          shreg_d[cnt_q] = dat_s2;
          tcnt_d = '0;
          if (cnt_q == LAST_BIT) begin
            state_d = PS2_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tcnt_q == TO_LAST) begin
          state_d = PS2_IDLE;
          cnt_d   = '0;
          tcnt_d  = '0;
          tout    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
    endcase
  end

  // The frame is judged one cycle after the stop bit lands in shreg.
  always_comb begin
    frame_ok = (shreg_q[10] == PS2_STOP) &&
               ps2_odd_ok(shreg_q[9:1]);
    push     = done_q && frame_ok && (!full || pop);
    ovf_set  = done_q && frame_ok && full && !pop;
    bad      = done_q && !frame_ok;
  end

  assign ready = !empty;
  assign pop   = !nextdata_n && ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad || tout;
      if (pop)
        overflow <= 1'b0;
      else if (ovf_set)
        overflow <= 1'b1;
    end
  end

  ps2_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .din   (shreg_q[8:1]),
    .dout  (data),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx.
// Drives PS/2 frames at 60 ns period, checks queue and flags.
module tb_ps2_keyboard_rx;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .FIFO_AW        (3),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always @(negedge clk)
    if (frame_err === 1'b1)
      errs++;

  function automatic logic [10:0] mk_frame(
    input logic [7:0] b, input logic flip);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ~(^b) ^ flip;
    f[10]  = 1'b1;
    return f;
  endfunction

  // Caller sits on a clk negedge.
  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic flip);
    logic [10:0] f;
    f = mk_frame(b, flip);
    @(negedge clk);
    for (int i = 0; i < 11; i++)
      ps2_bit(f[i]);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    nextdata_n = 1'b1;
    #23;
    tests++;
    if (ready !== 1'b0 || overflow !== 1'b0 ||
        frame_err !== 1'b0 || data !== 8'h00) begin
      fails++;
      $display("FAIL reset: rdy=%b ovf=%b err=%b data=%h want 0 0 0 00",
               ready, overflow, frame_err, data);
    end
    @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    logic [10:0] f;
    f = mk_frame(8'h1C, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: ready=%b want 0", ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (ready !== 1'b1 || data !== 8'h1C) begin
      fails++;
      $display("FAIL latency_4clk: ready=%b data=%h want 1 1c",
               ready, data);
    end
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    pop_one();
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL single_pop: ready=%b want 0", ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'hF0;
    exp[1] = 8'h1C;
    exp[2] = 8'h32;
    for (int i = 0; i < 3; i++)
      send_frame(exp[i], 1'b0);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ovf: overflow=%b want 0", overflow);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (ready !== 1'b1 || data !== exp[i]) begin
        fails++;
        $display("FAIL b2b_read%0d: ready=%b data=%h want 1 %h",
                 i, ready, data, exp[i]);
      end
      pop_one();
    end
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: ready=%b want 0", ready);
    end
  endtask

  task automatic test_parity_error();
    int base;
    base = errs;
    send_frame(8'h1C, 1'b1);
    tests++;
    if (errs - base != 1 || ready !== 1'b0) begin
      fails++;
      $display("FAIL parity_err: pulses=%0d ready=%b want 1 0",
               errs - base, ready);
    end
    send_frame(8'h29, 1'b0);
    tests++;
    if (ready !== 1'b1 || data !== 8'h29) begin
      fails++;
      $display("FAIL after_parity: ready=%b data=%h want 1 29",
               ready, data);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++)
      send_frame(8'(i), 1'b0);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_early: overflow=%b want 0", overflow);
    end
    send_frame(8'h09, 1'b0);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: overflow=%b want 1", overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if (ready !== 1'b1 || data !== 8'(i)) begin
        fails++;
        $display("FAIL ovf_read%0d: ready=%b data=%h want 1 %h",
                 i, ready, data, 8'(i));
      end
      pop_one();
      if (i == 1) begin
        tests++;
        if (overflow !== 1'b0) begin
          fails++;
          $display("FAIL ovf_clear: overflow=%b want 0", overflow);
        end
      end
    end
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL ovf_drop9: ready=%b data=%h want 0",
               ready, data);
    end
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    int base;
    base = errs;
    f = mk_frame(8'hA7, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      ps2_bit(f[i]);
    repeat (260) @(negedge clk);
    tests++;
    if (errs - base != 1 || ready !== 1'b0) begin
      fails++;
      $display("FAIL timeout: pulses=%0d ready=%b want 1 0",
               errs - base, ready);
    end
    send_frame(8'h5A, 1'b0);
    tests++;
    if (ready !== 1'b1 || data !== 8'h5A) begin
      fails++;
      $display("FAIL after_timeout: ready=%b data=%h want 1 5a",
               ready, data);
    end
    pop_one();
  endtask

  task automatic test_reset_midframe();
    logic [10:0] f;
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_prequeue: ready=%b want 1", ready);
    end
    f = mk_frame(8'h66, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      ps2_bit(f[i]);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b0 || overflow !== 1'b0 || data !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset: rdy=%b ovf=%b data=%h want 0 0 00",
               ready, overflow, data);
    end
    @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'h66, 1'b0);
    tests++;
    if (ready !== 1'b1 || data !== 8'h66) begin
      fails++;
      $display("FAIL mid_next: ready=%b data=%h want 1 66",
               ready, data);
    end
    pop_one();
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_only: ready=%b want 0", ready);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_parity_error();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Synthesizable host-side receiver for the PS/2 keyboard serial protocol. Keyboard drives ps2_clk and ps2_data; the host never drives them back.
- The block samples ps2_clk and ps2_data on the system clock, deframes 11-bit frames, and checks start, parity and stop bits.
- Valid scan codes go into a small FIFO. The CPU-side keyboard device reads the FIFO with a ready/next-data handshake.

Parameters:
- FIFO_AW, default 3: log2 of FIFO depth (default depth 8).
- TIMEOUT_CYCLES, default 50000: system-clock cycles with no ps2_clk falling edge before a partial frame is discarded.

Ports:
- clk  input  1  system clock.
- clrn  input  1  asynchronous active-low reset.
- ps2_clk  input  1  keyboard clock, asynchronous to clk.
- ps2_data  input  1  keyboard data, asynchronous to clk.
- nextdata_n  input  1  active-low pop request, one clk cycle per pop.
- data  output  8  FIFO head scan code; valid while ready=1.
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky: a frame was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse on a bad frame or a timeout.

Behaviour:
- Reset (clrn=0, asynchronous), all cleared:
  - sync flops set to 1;
  - bit counter=0, state IDLE;
  - FIFO pointers=0;
  - ready=0, overflow=0, frame_err=0;
  - data=8'h00 (head entry is don't-care but must read 0 after reset).
- Synchronisation:
  - ps2_clk and ps2_data each pass through 2 flops, then one history flop on clk.
  - fall = history & ~synced. Data is sampled from its synced copy on the cycle fall=1.
- States:
  - IDLE, on fall:
    - sampled bit 0 → RECV, cnt=1;
    - sampled bit 1 → stay IDLE; the glitch is ignored with no error.
  - RECV, on fall: shift sampled bit into shreg[cnt] and increment cnt. Bits 1..8 are data LSB first, bit 9 is parity, bit 10 is stop.
  - RECV, on the fall with cnt=10: evaluate the frame, return to IDLE with cnt=0.
    - valid = stop==1 and ^{data,parity}==1 (odd parity);
    - valid and FIFO not full → push;
    - valid and FIFO full → drop, overflow<=1;
    - invalid → drop, frame_err=1 for exactly one cycle.
- Timeout:
  - A counter runs in RECV and resets on every fall.
  - When it reaches TIMEOUT_CYCLES-1: IDLE, cnt=0, frame_err pulse, partial data discarded.
- Latency: ready rises exactly 4 clk cycles after the stop-bit falling edge on the ps2_clk pin, counted from an empty FIFO with the pin change captured at the first sync flop.
- FIFO and read handshake:
  - 2^FIFO_AW entries, pointers with an extra wrap bit. full = MSBs differ and the rest are equal.
  - data is driven combinationally from mem[rptr].
  - Pop when nextdata_n==0 and ready==1. A pop while empty is ignored.
  - A pop also clears overflow. overflow is otherwise sticky.
- Simultaneous push and pop:
  - Both take effect in the same cycle.
  - When full, the pop frees a slot, so the push succeeds and no overflow is raised.
  - When empty, the push proceeds; the pop is ignored because ready=0 that cycle.
- Holding nextdata_n low for several cycles pops one entry per cycle while ready=1.
- Reset mid-frame or with the FIFO non-empty: everything clears, and no partial frame survives.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_FRAME_BITS=11, PS2_START=0, PS2_STOP=1;
  - the state enum {PS2_IDLE, PS2_RECV}.
- One sub-module, ps2_fifo (parameter AW; ports push, pop, din, dout, empty, full), instantiated once. Deframing stays in the top.

Test Plan:
- Send 8'h1C (parity 0) at 60 ns ps2 period with clk 10 ns → ready=1 exactly 4 clk after the stop fall; data=8'h1C; pulse nextdata_n → ready=0.
- Send 8'hF0, 8'h1C, 8'h32 back-to-back, no reads → three entries; reads return F0, 1C, 32 in order; overflow=0.
- Send 8'h1C with the parity bit flipped to 1 → frame_err one-cycle pulse; ready stays 0. Then send 8'h29 → data=8'h29.
- Send 9 valid codes 8'h01..8'h09 with no reads → overflow=1 after the 9th; reads return 01..08; overflow clears on the first pop; 09 is absent.
- Send 5 bits, then hold ps2_clk high for more than TIMEOUT_CYCLES → frame_err pulse. Next frame 8'h5A → data=8'h5A; no misalignment.
- Pulse clrn low mid-frame (after bit 4) with 2 entries queued → ready=0 and overflow=0 immediately. Next full frame 8'h66 is received as the only entry.
